// File: rtl/p2v_stream_pkg.sv
// Shared types for the even_fib stream reducer: FSM states, default widths and the folded result.
package p2v_stream_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_SUM_W  = 48;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESULT = 2'd3
    } state_t;

    typedef struct packed {
        logic        [DEF_CNT_W-1:0]  count;
        logic signed [DEF_SUM_W-1:0]  sum;
        logic signed [DEF_DATA_W-1:0] min;
        logic signed [DEF_DATA_W-1:0] max;
        logic                         ovf;
    } result_t;

endpackage

// File: rtl/even_fib_reducer_if.sv
// Signal bundle tying the reducer to its upstream requester, its generator and the result consumer.
interface even_fib_reducer_if
    import p2v_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic                     __start;
    logic signed [DATA_W-1:0] n;
    logic                     __ready;
    logic                     __valid;
    logic                     __done;
    logic        [CNT_W-1:0]  __output_count;
    logic signed [SUM_W-1:0]  __output_sum;
    logic signed [DATA_W-1:0] __output_min;
    logic signed [DATA_W-1:0] __output_max;
    logic                     __output_ovf;
    logic                     gen_start;
    logic signed [DATA_W-1:0] gen_n;
    logic                     gen_ready;
    logic                     gen_valid;
    logic signed [DATA_W-1:0] gen_output;
    logic                     gen_done;

    // master is the environment (requester, consumer and generator); slave is the reducer
    modport master (
        output __start, n, __ready, gen_valid, gen_output, gen_done,
        input  __valid, __done, __output_count, __output_sum, __output_min,
               __output_max, __output_ovf, gen_start, gen_n, gen_ready
    );

    modport slave (
        input  __start, n, __ready, gen_valid, gen_output, gen_done,
        output __valid, __done, __output_count, __output_sum, __output_min,
               __output_max, __output_ovf, gen_start, gen_n, gen_ready
    );

endinterface

// File: rtl/stream_stats_acc.sv
// Folds an accepted element stream into count/sum/min/max with a sticky overflow flag.
module stream_stats_acc #(
    parameter int DATA_W = 32,
    parameter int SUM_W  = 48,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_accept,
    input  logic signed [DATA_W-1:0] i_data,
    output logic        [CNT_W-1:0]  o_count,
    output logic signed [SUM_W-1:0]  o_sum,
    output logic signed [DATA_W-1:0] o_min,
    output logic signed [DATA_W-1:0] o_max,
    output logic                     o_ovf
);

    logic        [CNT_W-1:0]  r_count;
    logic signed [SUM_W-1:0]  r_sum;
    logic signed [DATA_W-1:0] r_min;
    logic signed [DATA_W-1:0] r_max;
    logic                     r_ovf;

    logic signed [SUM_W-1:0]  w_addend;
    logic signed [SUM_W-1:0]  w_sum_next;
    logic                     w_sum_ovf;
    logic                     w_cnt_full;
    logic                     w_first;

    // Signed size cast sign-extends (or truncates) the element to the sum width
    assign w_addend   = SUM_W'(i_data);
    assign w_sum_next = r_sum + w_addend;
    assign w_sum_ovf  = (r_sum[SUM_W-1] == w_addend[SUM_W-1]) &&
                        (w_sum_next[SUM_W-1] != r_sum[SUM_W-1]);
    assign w_cnt_full = &r_count;
    assign w_first    = (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_sum   <= '0;
            r_min   <= '0;
            r_max   <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_sum   <= '0;
            r_min   <= '0;
            r_max   <= '0;
            r_ovf   <= 1'b0;
        end else if (i_accept) begin
            if (!w_cnt_full) begin
                r_count <= r_count + CNT_W'(1);
            end
            r_sum <= w_sum_next;
            r_min <= (w_first || (i_data < r_min)) ? i_data : r_min;
            r_max <= (w_first || (i_data > r_max)) ? i_data : r_max;
            r_ovf <= r_ovf | w_sum_ovf | w_cnt_full;
        end
    end

    assign o_count = r_count;
    assign o_sum   = r_sum;
    assign o_min   = r_min;
    assign o_max   = r_max;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/even_fib_reducer.sv
// Launches a generator, drains its yield stream and hands the folded statistics downstream as one beat.
module even_fib_reducer
    import p2v_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              __clock,
    input  logic              __reset_n,
    even_fib_reducer_if.slave bus
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic signed [DATA_W-1:0] r_gen_n;

    logic w_clear;
    logic w_accept;
    logic w_gen_start;
    logic w_gen_ready;
    logic w_valid;

    always_ff @(posedge __clock or negedge __reset_n) begin
        if (!__reset_n) begin
            r_state <= IDLE;
            r_gen_n <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clear) begin
                r_gen_n <= bus.n;
            end
        end
    end

    // Handshake outputs decode straight from state so reset drops them without waiting for a clock
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        w_gen_start  = 1'b0;
        w_gen_ready  = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.__start) begin
                    w_clear      = 1'b1;
                    w_state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                w_gen_start  = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                w_gen_ready = 1'b1;
                w_accept    = bus.gen_valid;
                if (bus.gen_done) begin
                    w_state_next = RESULT;
                end
            end
            RESULT: begin
                w_valid = 1'b1;
                if (bus.__ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    stream_stats_acc #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .CNT_W  (CNT_W)
    ) u_acc (
        .clk      (__clock),
        .rst_n    (__reset_n),
        .i_clear  (w_clear),
        .i_accept (w_accept),
        .i_data   (bus.gen_output),
        .o_count  (bus.__output_count),
        .o_sum    (bus.__output_sum),
        .o_min    (bus.__output_min),
        .o_max    (bus.__output_max),
        .o_ovf    (bus.__output_ovf)
    );

    assign bus.gen_start = w_gen_start;
    assign bus.gen_ready = w_gen_ready;
    assign bus.gen_n     = r_gen_n;
    assign bus.__valid   = w_valid;
    assign bus.__done    = w_valid;

endmodule

// File: tb/tb_even_fib_reducer.sv
// Scoreboard bench: two reducers (48-bit and 8-bit sum) paired with a behavioural even_fib generator.
module tb_even_fib_reducer;
    import p2v_stream_pkg::*;

    logic clock = 1'b0;
    logic resetN;
    always #5 clock = ~clock;

    logic                     sel;
    logic                     startReq;
    logic signed [31:0]       nReq;
    logic                     readyReq;
    logic                     genValid;
    logic signed [31:0]       genOutput;
    logic                     genDone;

    int checks   = 0;
    int failures = 0;
    int genStartSeen = 0;
    result_t expQ[$];

    even_fib_reducer_if #(.DATA_W(32), .SUM_W(48), .CNT_W(16)) ifM ();
    even_fib_reducer_if #(.DATA_W(32), .SUM_W(8),  .CNT_W(16)) ifS ();

    even_fib_reducer #(.DATA_W(32), .SUM_W(48), .CNT_W(16)) dutM (
        .__clock   (clock),
        .__reset_n (resetN),
        .bus       (ifM.slave)
    );

    even_fib_reducer #(.DATA_W(32), .SUM_W(8), .CNT_W(16)) dutS (
        .__clock   (clock),
        .__reset_n (resetN),
        .bus       (ifS.slave)
    );

    assign ifM.__start    = startReq && !sel;
    assign ifS.__start    = startReq && sel;
    assign ifM.n          = nReq;
    assign ifS.n          = nReq;
    assign ifM.__ready    = readyReq;
    assign ifS.__ready    = readyReq;
    assign ifM.gen_valid  = genValid;
    assign ifS.gen_valid  = genValid;
    assign ifM.gen_output = genOutput;
    assign ifS.gen_output = genOutput;
    assign ifM.gen_done   = genDone;
    assign ifS.gen_done   = genDone;

    // View of whichever reducer the current run targets, widened for comparison
    logic   selGenStart, selGenReady, selValid, selDone, selOvf;
    longint selCount, selSum, selMin, selMax, selGenN;
    assign selGenStart = sel ? ifS.gen_start    : ifM.gen_start;
    assign selGenReady = sel ? ifS.gen_ready    : ifM.gen_ready;
    assign selValid    = sel ? ifS.__valid      : ifM.__valid;
    assign selDone     = sel ? ifS.__done       : ifM.__done;
    assign selOvf      = sel ? ifS.__output_ovf : ifM.__output_ovf;
    assign selCount    = sel ? longint'(ifS.__output_count) : longint'(ifM.__output_count);
    assign selSum      = sel ? longint'(ifS.__output_sum)   : longint'(ifM.__output_sum);
    assign selMin      = sel ? longint'(ifS.__output_min)   : longint'(ifM.__output_min);
    assign selMax      = sel ? longint'(ifS.__output_max)   : longint'(ifM.__output_max);
    assign selGenN     = sel ? longint'(ifS.gen_n)          : longint'(ifM.gen_n);

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    function automatic longint wrapTo(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // Reference fold of the odd Fibonacci numbers below n at a given sum width
    function automatic result_t modelReduce(input longint nVal, input int sumW);
        result_t r;
        longint a = 1, b = 1, t, s = 0, raw, mn = 0, mx = 0;
        int     cnt = 0;
        bit     ovf = 1'b0;
        while (a < nVal) begin
            if ((a % 2) == 1) begin
                raw = s + a;
                s   = wrapTo(raw, sumW);
                if (s != raw) ovf = 1'b1;
                if (cnt == 0) begin
                    mn = a;
                    mx = a;
                end else begin
                    if (a < mn) mn = a;
                    if (a > mx) mx = a;
                end
                cnt++;
            end
            t = a + b;
            a = b;
            b = t;
        end
        r.count = 16'(cnt);
        r.sum   = 48'(s);
        r.min   = 32'(mn);
        r.max   = 32'(mx);
        r.ovf   = ovf;
        return r;
    endfunction

    // Behavioural even_fib: yields odd fibs below gen_n, holding each until accepted
    task automatic driveGenerator();
        longint a = 1, b = 1, t, limit;
        int     guard;
        limit = selGenN;
        while (a < limit) begin
            if ((a % 2) == 1) begin
                genValid  = 1'b1;
                genOutput = 32'(a);
                guard = 0;
                while (!selGenReady && resetN && guard < 100) begin
                    @(negedge clock);
                    guard++;
                end
                if (!resetN || guard >= 100) begin
                    if (resetN) checkOutput("genReadyWait", selGenReady, 1);
                    genValid = 1'b0;
                    return;
                end
                @(negedge clock);
                if (!resetN) begin
                    genValid = 1'b0;
                    return;
                end
            end
            t = a + b;
            a = b;
            b = t;
        end
        genValid = 1'b0;
        genDone  = 1'b1;
        guard = 0;
        while (!selGenReady && resetN && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (resetN && guard >= 100) checkOutput("genDoneWait", selGenReady, 1);
        @(negedge clock);
        genDone = 1'b0;
        if (resetN) checkOutput("doneToValid", selValid, 1);
    endtask

    initial begin
        genValid  = 1'b0;
        genOutput = '0;
        genDone   = 1'b0;
        forever begin
            @(negedge clock);
            if (resetN && selGenStart) driveGenerator();
        end
    end

    always @(negedge clock) begin
        if (resetN && selGenStart) genStartSeen++;
    end

    task automatic applyStimulus(input logic useSmall, input int nVal, input int holdCycles,
                                 input bit pokeStart);
        result_t exp;
        int      guard;
        int      startsBefore;
        sel = useSmall;
        expQ.push_back(modelReduce(nVal, useSmall ? 8 : 48));
        startsBefore = genStartSeen;
        readyReq = (holdCycles == 0);
        nReq     = nVal;
        startReq = 1'b1;
        @(negedge clock);
        startReq = 1'b0;
        checkOutput("genStartLatency", selGenStart, 1);
        checkOutput("genN", selGenN, nVal);
        if (pokeStart) begin
            repeat (3) @(negedge clock);
            startReq = 1'b1;
            nReq     = 5;
            @(negedge clock);
            startReq = 1'b0;
            checkOutput("genNHeld", selGenN, nVal);
            nReq = nVal;
        end
        guard = 0;
        while (!selValid && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("validSeen", selValid, 1);
        if (selValid) begin
            exp = expQ.pop_front();
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clock);
                checkOutput("holdValid", selValid, 1);
                checkOutput("holdSum", selSum, longint'(exp.sum));
                checkOutput("holdCount", selCount, longint'(exp.count));
            end
            readyReq = 1'b1;
            checkOutput("done", selDone, 1);
            checkOutput("count", selCount, longint'(exp.count));
            checkOutput("sum", selSum, longint'(exp.sum));
            checkOutput("min", selMin, longint'(exp.min));
            checkOutput("max", selMax, longint'(exp.max));
            checkOutput("ovf", selOvf, longint'(exp.ovf));
            @(negedge clock);
            checkOutput("singleBeat", selValid, 0);
            checkOutput("resultHeld", selSum, longint'(exp.sum));
        end
        checkOutput("genStartsPerRun", genStartSeen - startsBefore, 1);
    endtask

    initial begin
        int guard;
        resetN   = 1'b0;
        sel      = 1'b0;
        startReq = 1'b0;
        nReq     = '0;
        readyReq = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("rstValid", selValid, 0);
        checkOutput("rstDone", selDone, 0);
        checkOutput("rstGenStart", selGenStart, 0);
        checkOutput("rstGenReady", selGenReady, 0);
        checkOutput("rstGenN", selGenN, 0);
        checkOutput("rstCount", selCount, 0);
        checkOutput("rstSum", selSum, 0);
        checkOutput("rstOvf", selOvf, 0);
        checkOutput("rstSmallValid", ifS.__valid, 0);
        resetN = 1'b1;
        @(negedge clock);

        $display("[TB] basic runs");
        applyStimulus(1'b0, 10, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1, 0, 1'b0);
        applyStimulus(1'b0, 100, 0, 1'b0);

        $display("[TB] narrow sum wrap");
        applyStimulus(1'b1, 100, 0, 1'b0);
        applyStimulus(1'b1, 10, 0, 1'b0);

        $display("[TB] downstream backpressure");
        applyStimulus(1'b0, 10, 5, 1'b0);

        $display("[TB] reset mid-run");
        sel      = 1'b0;
        readyReq = 1'b1;
        nReq     = 10;
        startReq = 1'b1;
        @(negedge clock);
        startReq = 1'b0;
        guard = 0;
        while (selCount < 2 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("preResetCount", selCount, 2);
        #2 resetN = 1'b0;
        #1;
        checkOutput("midRstGenReady", selGenReady, 0);
        checkOutput("midRstValid", selValid, 0);
        checkOutput("midRstCount", selCount, 0);
        checkOutput("midRstSum", selSum, 0);
        checkOutput("midRstMax", selMax, 0);
        checkOutput("midRstGenN", selGenN, 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        applyStimulus(1'b0, 10, 0, 1'b0);

        $display("[TB] start during run");
        applyStimulus(1'b0, 100, 0, 1'b1);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
